// File: rtl/sram_axi_bridge.sv
// sram_axi_bridge
//   Bridges the CPU's two SRAM-like master ports (instruction fetch and data
//   load/store) onto a single AXI3 master port. It arbitrates reads on AR,
//   sequences AW/W/B for stores, routes R beats back to their owner by ID,
//   and keeps a data load from overtaking an outstanding store.
//
// Ports
//   clk, reset              clock, synchronous active-high reset
//   inst_sram_*             instruction master (read-only; wr/wstrb/wdata ignored)
//   data_sram_*             data master (wr=1 store, wr=0 load)
//   *_addr_ok               combinational accept, handshake = req && addr_ok
//   *_data_ok               one-cycle pulse: rdata valid / store completed
//   ar*, r*, aw*, w*, b*    AXI3 master channels (single-beat, INCR, ID 0=inst, 1=data)

module sram_axi_bridge #(
  parameter int DATA_PRIO   = 1,  // 1: data read beats inst read on a same-cycle tie
  parameter int WR_BLOCK_RD = 1   // 1: hold off data loads while a store is in flight
) (
  input  logic        clk,
  input  logic        reset,
  // instruction master
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  // data master
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  // AR channel
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [3:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  // R channel
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  // AW channel
  output logic [3:0]  awid,
  output logic [31:0] awaddr,
  output logic [3:0]  awlen,
  output logic [2:0]  awsize,
  output logic [1:0]  awburst,
  output logic [1:0]  awlock,
  output logic [3:0]  awcache,
  output logic [2:0]  awprot,
  output logic        awvalid,
  input  logic        awready,
  // W channel
  output logic [3:0]  wid,
  output logic [31:0] wdata,
  output logic [3:0]  wstrb,
  output logic        wlast,
  output logic        wvalid,
  input  logic        wready,
  // B channel
  input  logic [3:0]  bid,
  input  logic [1:0]  bresp,
  input  logic        bvalid,
  output logic        bready
);

  typedef enum logic {AR_IDLE, AR_SEND} ar_state_t;
  typedef enum logic [1:0] {W_IDLE, W_SEND, W_BRESP} w_state_t;

  ar_state_t  ar_state;
  w_state_t   w_state;
  logic       ar_is_data;     // the address in flight on AR belongs to the data master
  logic [1:0] rd_pending;     // bit per AXI ID: a read is outstanding

  // Single-beat transfers with fixed attributes; stores always use ID 1.
  assign arlen   = 4'd0;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'd0;
  assign arprot  = 3'd0;
  assign awid    = 4'd1;
  assign awlen   = 4'd0;
  assign awburst = 2'b01;
  assign awlock  = 2'b00;
  assign awcache = 4'd0;
  assign awprot  = 3'd0;
  assign wid     = 4'd1;
  assign wlast   = 1'b1;
  assign arid    = {3'b000, ar_is_data};

  logic unused_in;
  assign unused_in = ^{inst_sram_wr, inst_sram_wstrb, inst_sram_wdata,
                       rresp, rlast, bid, bresp};

  // ---------------- request eligibility and arbitration ----------------
  logic ar_busy;
  logic inst_rd_elig, data_rd_elig, data_wr_elig;
  logic inst_rd_acc, data_rd_acc, data_wr_acc;

  assign ar_busy      = (ar_state == AR_SEND);
  assign inst_rd_elig = inst_sram_req && !rd_pending[0] && !ar_busy;
  assign data_rd_elig = data_sram_req && !data_sram_wr && !rd_pending[1] && !ar_busy
                        && !((WR_BLOCK_RD != 0) && (w_state != W_IDLE));
  // A store waits for any data load to drain so the two never overlap.
  assign data_wr_elig = data_sram_req && data_sram_wr && (w_state == W_IDLE)
                        && !rd_pending[1] && !(ar_busy && ar_is_data);

  assign data_rd_acc = !reset && data_rd_elig && ((DATA_PRIO != 0) || !inst_rd_elig);
  assign inst_rd_acc = !reset && inst_rd_elig && ((DATA_PRIO == 0) || !data_rd_elig);
  assign data_wr_acc = !reset && data_wr_elig;

  assign inst_sram_addr_ok = inst_rd_acc;
  assign data_sram_addr_ok = data_rd_acc || data_wr_acc;

  // ---------------- AR channel FSM ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      ar_state   <= AR_IDLE;
      arvalid    <= 1'b0;
      ar_is_data <= 1'b0;
    end else begin
      case (ar_state)
        AR_IDLE: begin
          if (inst_rd_acc) begin
            ar_state   <= AR_SEND;
            arvalid    <= 1'b1;
            ar_is_data <= 1'b0;
            araddr     <= inst_sram_addr;
            arsize     <= {1'b0, inst_sram_size};
          end else if (data_rd_acc) begin
            ar_state   <= AR_SEND;
            arvalid    <= 1'b1;
            ar_is_data <= 1'b1;
            araddr     <= data_sram_addr;
            arsize     <= {1'b0, data_sram_size};
          end
        end
        AR_SEND: begin
          if (arready) begin
            ar_state <= AR_IDLE;
            arvalid  <= 1'b0;
          end
        end
        default: ar_state <= AR_IDLE;
      endcase
    end
  end

  // ---------------- R channel: pending tracking and routing ----------------
  logic r_fire, r_to_inst, r_to_data, b_done;

  assign rready    = |rd_pending;
  assign r_fire    = rvalid && rready;
  // Beats whose ID has nothing outstanding are consumed and dropped.
  assign r_to_inst = r_fire && (rid == 4'd0) && rd_pending[0];
  assign r_to_data = r_fire && (rid == 4'd1) && rd_pending[1];
  assign b_done    = (w_state == W_BRESP) && bvalid && bready;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pending        <= 2'b00;
      inst_sram_data_ok <= 1'b0;
      data_sram_data_ok <= 1'b0;
      inst_sram_rdata   <= 32'd0;
      data_sram_rdata   <= 32'd0;
    end else begin
      rd_pending        <= (rd_pending | {data_rd_acc, inst_rd_acc})
                           & ~{r_to_data, r_to_inst};
      inst_sram_data_ok <= r_to_inst;
      data_sram_data_ok <= r_to_data || b_done;
      if (r_to_inst) inst_sram_rdata <= rdata;
      if (r_to_data) data_sram_rdata <= rdata;
    end
  end

  // ---------------- AW/W/B channel FSM ----------------
  logic aw_left, w_left;

  // AW and W handshake independently; each valid drops after its own handshake.
  assign aw_left = awvalid && !awready;
  assign w_left  = wvalid && !wready;

  always_ff @(posedge clk) begin
    if (reset) begin
      w_state <= W_IDLE;
      awvalid <= 1'b0;
      wvalid  <= 1'b0;
      bready  <= 1'b0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (data_wr_acc) begin
            w_state <= W_SEND;
            awvalid <= 1'b1;
            wvalid  <= 1'b1;
            awaddr  <= data_sram_addr;
            awsize  <= {1'b0, data_sram_size};
            wdata   <= data_sram_wdata;
            wstrb   <= data_sram_wstrb;
          end
        end
        W_SEND: begin
          awvalid <= aw_left;
          wvalid  <= w_left;
          if (!aw_left && !w_left) begin
            w_state <= W_BRESP;
            bready  <= 1'b1;
          end
        end
        W_BRESP: begin
          if (bvalid) begin
            w_state <= W_IDLE;
            bready  <= 1'b0;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_axi_bridge.sv
module tb_sram_axi_bridge;

  logic        clk = 1'b0;
  logic        reset;
  logic        inst_sram_req, inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr, inst_sram_wdata;
  logic [3:0]  inst_sram_wstrb;
  logic        inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic        data_sram_req, data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_addr, data_sram_wdata;
  logic        data_sram_addr_ok, data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic [3:0]  arid, arlen, arcache;
  logic [31:0] araddr;
  logic [2:0]  arsize, arprot;
  logic [1:0]  arburst, arlock;
  logic        arvalid, arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast, rvalid, rready;
  logic [3:0]  awid, awlen, awcache;
  logic [31:0] awaddr;
  logic [2:0]  awsize, awprot;
  logic [1:0]  awburst, awlock;
  logic        awvalid, awready;
  logic [3:0]  wid, wstrb;
  logic [31:0] wdata;
  logic        wlast, wvalid, wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid, bready;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sram_axi_bridge #(.DATA_PRIO(1), .WR_BLOCK_RD(1)) dut (
    .clk(clk), .reset(reset),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr),
    .inst_sram_size(inst_sram_size), .inst_sram_addr(inst_sram_addr),
    .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok),
    .inst_sram_rdata(inst_sram_rdata),
    .data_sram_req(data_sram_req), .data_sram_wr(data_sram_wr),
    .data_sram_size(data_sram_size), .data_sram_wstrb(data_sram_wstrb),
    .data_sram_addr(data_sram_addr), .data_sram_wdata(data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok), .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata(data_sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid),
    .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid),
    .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid),
    .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid),
    .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, act, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    inst_sram_req = 1'b0; inst_sram_wr = 1'b0; inst_sram_size = 2'd2;
    inst_sram_addr = 32'd0; inst_sram_wstrb = 4'd0; inst_sram_wdata = 32'd0;
    data_sram_req = 1'b0; data_sram_wr = 1'b0; data_sram_size = 2'd2;
    data_sram_wstrb = 4'd0; data_sram_addr = 32'd0; data_sram_wdata = 32'd0;
    arready = 1'b0; rid = 4'd0; rdata = 32'd0; rresp = 2'd0; rlast = 1'b1;
    rvalid = 1'b0; awready = 1'b0; wready = 1'b0; bid = 4'd1; bresp = 2'd0;
    bvalid = 1'b0;

    // ---- reset state ----
    step(); step();
    check("rst_arvalid", 32'(arvalid), 32'd0);
    check("rst_awvalid", 32'(awvalid), 32'd0);
    check("rst_wvalid",  32'(wvalid),  32'd0);
    check("rst_bready",  32'(bready),  32'd0);
    check("rst_rready",  32'(rready),  32'd0);
    check("rst_inst_dok", 32'(inst_sram_data_ok), 32'd0);
    check("rst_data_dok", 32'(data_sram_data_ok), 32'd0);
    check("rst_inst_rdata", inst_sram_rdata, 32'd0);
    check("rst_data_rdata", data_sram_rdata, 32'd0);
    reset = 1'b0;
    step();

    // ---- 1: single inst read ----
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0000; #1;
    check("t1_inst_aok", 32'(inst_sram_addr_ok), 32'd1);
    step();
    inst_sram_req = 1'b0;
    check("t1_arvalid", 32'(arvalid), 32'd1);
    check("t1_arid",    32'(arid),    32'd0);
    check("t1_araddr",  araddr,       32'h1C00_0000);
    check("t1_arsize",  32'(arsize),  32'd2);
    arready = 1'b1;
    step();
    arready = 1'b0;
    check("t1_arvalid_drop", 32'(arvalid), 32'd0);
    check("t1_rready", 32'(rready), 32'd1);
    step();
    rvalid = 1'b1; rid = 4'd0; rdata = 32'h0280_0C0C; #1;
    check("t1_dok_early", 32'(inst_sram_data_ok), 32'd0);
    step();
    rvalid = 1'b0;
    check("t1_inst_dok", 32'(inst_sram_data_ok), 32'd1);
    check("t1_inst_rdata", inst_sram_rdata, 32'h0280_0C0C);
    check("t1_data_dok", 32'(data_sram_data_ok), 32'd0);
    step();
    check("t1_dok_pulse", 32'(inst_sram_data_ok), 32'd0);
    check("t1_rdata_hold", inst_sram_rdata, 32'h0280_0C0C);
    check("t1_rready_idle", 32'(rready), 32'd0);

    // ---- 2: simultaneous inst and data reads, data wins ----
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0004;
    data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_addr = 32'h1C00_0200; #1;
    check("t2_data_aok", 32'(data_sram_addr_ok), 32'd1);
    check("t2_inst_aok", 32'(inst_sram_addr_ok), 32'd0);
    step();
    data_sram_req = 1'b0; #1;
    check("t2_arid_data", 32'(arid), 32'd1);
    check("t2_araddr_data", araddr, 32'h1C00_0200);
    check("t2_inst_aok_send", 32'(inst_sram_addr_ok), 32'd0);
    arready = 1'b1;
    step();
    arready = 1'b0; #1;
    check("t2_inst_aok_after", 32'(inst_sram_addr_ok), 32'd1);
    step();
    inst_sram_req = 1'b0;
    check("t2_arid_inst", 32'(arid), 32'd0);
    check("t2_araddr_inst", araddr, 32'h1C00_0004);
    arready = 1'b1;
    step();
    arready = 1'b0;
    rvalid = 1'b1; rid = 4'd0; rdata = 32'hAAAA_0001;
    step();
    check("t2_inst_dok", 32'(inst_sram_data_ok), 32'd1);
    check("t2_inst_rdata", inst_sram_rdata, 32'hAAAA_0001);
    check("t2_data_dok_none", 32'(data_sram_data_ok), 32'd0);
    // stale beat on ID 0: consumed, not delivered
    rid = 4'd0; rdata = 32'hDEAD_BEEF; #1;
    check("t2_rready_stale", 32'(rready), 32'd1);
    step();
    check("t2_stale_inst_dok", 32'(inst_sram_data_ok), 32'd0);
    check("t2_stale_data_dok", 32'(data_sram_data_ok), 32'd0);
    check("t2_stale_rdata", inst_sram_rdata, 32'hAAAA_0001);
    rid = 4'd1; rdata = 32'hBBBB_0002;
    step();
    rvalid = 1'b0;
    check("t2_data_dok", 32'(data_sram_data_ok), 32'd1);
    check("t2_data_rdata", data_sram_rdata, 32'hBBBB_0002);
    check("t2_inst_dok_none", 32'(inst_sram_data_ok), 32'd0);
    step();

    // ---- 3: store with immediate wready, awready after 3 cycles ----
    data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'h1C00_0100;
    data_sram_wstrb = 4'b0011; data_sram_wdata = 32'h0000_1234; #1;
    check("t3_aok", 32'(data_sram_addr_ok), 32'd1);
    step();
    data_sram_req = 1'b0;
    check("t3_awvalid1", 32'(awvalid), 32'd1);
    check("t3_wvalid1",  32'(wvalid),  32'd1);
    check("t3_awaddr",   awaddr,       32'h1C00_0100);
    check("t3_awsize",   32'(awsize),  32'd2);
    check("t3_wstrb",    32'(wstrb),   32'h3);
    check("t3_wdata",    wdata,        32'h0000_1234);
    wready = 1'b1;
    step();
    wready = 1'b0;
    for (int i = 2; i <= 4; i++) begin
      check($sformatf("t3_awvalid%0d", i), 32'(awvalid), 32'd1);
      check($sformatf("t3_wvalid%0d", i),  32'(wvalid),  32'd0);
      check($sformatf("t3_bready%0d", i),  32'(bready),  32'd0);
      if (i == 4) awready = 1'b1;
      step();
    end
    awready = 1'b0;
    check("t3_awvalid_drop", 32'(awvalid), 32'd0);
    check("t3_bready", 32'(bready), 32'd1);
    check("t3_dok_early", 32'(data_sram_data_ok), 32'd0);
    bvalid = 1'b1;
    step();
    bvalid = 1'b0;
    check("t3_dok", 32'(data_sram_data_ok), 32'd1);
    check("t3_bready_drop", 32'(bready), 32'd0);
    step();
    check("t3_dok_pulse", 32'(data_sram_data_ok), 32'd0);

    // ---- 4: load blocked behind store, inst read proceeds ----
    data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'h1C00_0104;
    data_sram_wstrb = 4'b1111; data_sram_wdata = 32'hCAFE_F00D; #1;
    check("t4_st_aok", 32'(data_sram_addr_ok), 32'd1);
    step();
    awready = 1'b1; wready = 1'b1;
    data_sram_wr = 1'b0; data_sram_addr = 32'h1C00_0300;
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0010; #1;
    check("t4_ld_blk_send", 32'(data_sram_addr_ok), 32'd0);
    check("t4_inst_aok", 32'(inst_sram_addr_ok), 32'd1);
    step();
    awready = 1'b0; wready = 1'b0; inst_sram_req = 1'b0;
    check("t4_bready", 32'(bready), 32'd1);
    check("t4_arid_inst", 32'(arid), 32'd0);
    arready = 1'b1; bvalid = 1'b1; #1;
    check("t4_ld_blk_bresp", 32'(data_sram_addr_ok), 32'd0);
    step();
    arready = 1'b0; bvalid = 1'b0; #1;
    check("t4_st_dok", 32'(data_sram_data_ok), 32'd1);
    check("t4_ld_aok", 32'(data_sram_addr_ok), 32'd1);
    step();
    data_sram_req = 1'b0;
    check("t4_dok_pulse", 32'(data_sram_data_ok), 32'd0);
    check("t4_arid_data", 32'(arid), 32'd1);
    check("t4_araddr_data", araddr, 32'h1C00_0300);
    arready = 1'b1;
    step();
    arready = 1'b0;
    rvalid = 1'b1; rid = 4'd1; rdata = 32'h1111_2222;
    step();
    check("t4_ld_dok", 32'(data_sram_data_ok), 32'd1);
    check("t4_ld_rdata", data_sram_rdata, 32'h1111_2222);
    check("t4_inst_dok_none", 32'(inst_sram_data_ok), 32'd0);
    rid = 4'd0; rdata = 32'h3333_4444;
    step();
    rvalid = 1'b0;
    check("t4_inst_dok", 32'(inst_sram_data_ok), 32'd1);
    check("t4_inst_rdata", inst_sram_rdata, 32'h3333_4444);
    step();

    // ---- 5: arready held low for 5 cycles ----
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0040; #1;
    check("t5_aok", 32'(inst_sram_addr_ok), 32'd1);
    step();
    inst_sram_addr = 32'h1C00_0044;
    data_sram_req = 1'b1; data_sram_wr = 1'b0; data_sram_addr = 32'h1C00_0400;
    for (int i = 1; i <= 5; i++) begin
      #1;
      check($sformatf("t5_arvalid%0d", i), 32'(arvalid), 32'd1);
      check($sformatf("t5_araddr%0d", i),  araddr,       32'h1C00_0040);
      check($sformatf("t5_arid%0d", i),    32'(arid),    32'd0);
      check($sformatf("t5_arsize%0d", i),  32'(arsize),  32'd2);
      check($sformatf("t5_inst_aok%0d", i), 32'(inst_sram_addr_ok), 32'd0);
      check($sformatf("t5_data_aok%0d", i), 32'(data_sram_addr_ok), 32'd0);
      step();
    end
    inst_sram_req = 1'b0; data_sram_req = 1'b0; arready = 1'b1;
    check("t5_arvalid6", 32'(arvalid), 32'd1);
    step();
    arready = 1'b0;
    check("t5_arvalid_drop", 32'(arvalid), 32'd0);
    rvalid = 1'b1; rid = 4'd0; rdata = 32'h5555_6666;
    step();
    rvalid = 1'b0;
    check("t5_inst_dok", 32'(inst_sram_data_ok), 32'd1);
    check("t5_inst_rdata", inst_sram_rdata, 32'h5555_6666);
    step();

    // ---- 6: reset during AR SEND and W SEND ----
    inst_sram_req = 1'b1; inst_sram_addr = 32'h1C00_0080;
    data_sram_req = 1'b1; data_sram_wr = 1'b1; data_sram_addr = 32'h1C00_0180;
    data_sram_wdata = 32'h0BAD_CAFE; #1;
    check("t6_inst_aok", 32'(inst_sram_addr_ok), 32'd1);
    check("t6_st_aok", 32'(data_sram_addr_ok), 32'd1);
    step();
    inst_sram_req = 1'b0; data_sram_req = 1'b0;
    check("t6_arvalid_pre", 32'(arvalid), 32'd1);
    check("t6_awvalid_pre", 32'(awvalid), 32'd1);
    check("t6_rready_pre",  32'(rready),  32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("t6_arvalid", 32'(arvalid), 32'd0);
    check("t6_awvalid", 32'(awvalid), 32'd0);
    check("t6_wvalid",  32'(wvalid),  32'd0);
    check("t6_bready",  32'(bready),  32'd0);
    check("t6_rready",  32'(rready),  32'd0);
    check("t6_inst_rdata", inst_sram_rdata, 32'd0);
    rvalid = 1'b1; rid = 4'd0; rdata = 32'h7777_8888; bvalid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check($sformatf("t6_inst_dok%0d", i), 32'(inst_sram_data_ok), 32'd0);
      check($sformatf("t6_data_dok%0d", i), 32'(data_sram_data_ok), 32'd0);
    end
    rvalid = 1'b0; bvalid = 1'b0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
